// File: rtl/aes_sbox.sv
// aes_sbox: FIPS-197 forward S-box, computed as the affine map of the GF(2^8) inverse.
// Define AES_SBOX_REG_EN for one output register stage with an async reset to 0x63.
module aes_sbox (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] a,
   output logic [7:0] d
);
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] t;
      p = '0;
      t = x;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (y[i] ? t : 8'h00);
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 = a^-1 for a != 0 and yields 0 for a == 0, so no special case is needed
   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] s;
      logic [7:0] r;
      s = gmul(x, x);
      r = s;
      for (int k = 2; k < 8; k++) begin
         s = gmul(s, s);
         r = gmul(r, s);
      end
      return r;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ {b[3:0], b[7:4]} ^ {b[4:0], b[7:5]} ^ {b[5:0], b[7:6]} ^ {b[6:0], b[7]} ^ 8'h63;
   endfunction

   logic [7:0] s_d;
   assign s_d = affine(ginv(a));

`ifdef AES_SBOX_REG_EN
   logic [7:0] d_q;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) d_q <= 8'h63;
      else     d_q <= s_d;
   end
   assign d = d_q;
`else
   logic unused_clk_rst;
   assign unused_clk_rst = CLK ^ RST;
   assign d = s_d;
`endif
endmodule

// File: tb/tb_aes_sbox.sv
// tb_aes_sbox: scoreboard bench for aes_sbox; expectations come from the FIPS-197 table.
module tb_aes_sbox;
   logic       CLK = 0;
   logic       RST;
   logic [7:0] a;
   logic [7:0] d;

   aes_sbox dut (.CLK(CLK), .RST(RST), .a(a), .d(d));

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] a;
      logic [7:0] exp;
      int         kx;
      bit         sw;
   } ent_t;

   ent_t q[$];
   int   total = 0;
   int   bad = 0;
   bit   seen[256];
   logic [7:0] kw[4];

   logic [7:0] fips[256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   logic [7:0] spot_a[8] = '{8'h00, 8'h01, 8'h53, 8'h10, 8'h80, 8'h09, 8'h52, 8'hff};
   logic [7:0] spot_e[8] = '{8'h63, 8'h7c, 8'hed, 8'hca, 8'hcd, 8'h01, 8'h00, 8'h16};
   logic [7:0] kx_a[4]   = '{8'hcf, 8'h4f, 8'h3c, 8'h09};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] av, input logic [7:0] ev, input int kx, input bit sw);
      @(negedge CLK);
      a = av;
      q.push_back('{a: av, exp: ev, kx: kx, sw: sw});
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 10) begin
         @(posedge CLK);
         n++;
      end
      #2;
      if (q.size() != 0) begin
         chk("drain_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   // monitor: one expected byte per cycle, sampled just after the rising edge
   initial begin
      ent_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk($sformatf("sbox a=%h", e.a), {24'h0, d}, {24'h0, e.exp});
            if (e.sw) seen[d] = 1'b1;
            if (e.kx >= 0) kw[e.kx] = d;
            if (e.kx == 3)
               chk("keyexp_w4", {kw[0], kw[1], kw[2], kw[3]} ^ 32'h2b7e1516 ^ 32'h01000000, 32'ha0fafe17);
         end
      end
   end

   initial begin
      int uniq;
      RST = 1'b1;
      a = 8'hff;
`ifdef AES_SBOX_REG_EN
      #1 chk("rst_async", {24'h0, d}, 32'h63);
      @(posedge CLK);
      #1 chk("rst_hold", {24'h0, d}, 32'h63);
      @(negedge CLK);
      RST = 1'b0;
      q.push_back('{a: 8'hff, exp: 8'h16, kx: -1, sw: 1'b0});
      drain();
      send(8'h00, 8'h63, -1, 1'b0);
      send(8'h01, 8'h7c, -1, 1'b0);
      send(8'h53, 8'hed, -1, 1'b0);
      drain();
      @(negedge CLK);
      a = 8'h01;
      #2 RST = 1'b1;
      #1 chk("rst_mid_async", {24'h0, d}, 32'h63);
      @(posedge CLK);
      #1 chk("rst_mid_hold", {24'h0, d}, 32'h63);
      @(negedge CLK);
      RST = 1'b0;
`else
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      send(8'h00, 8'h63, -1, 1'b0);
      send(8'h01, 8'h7c, -1, 1'b0);
      send(8'h53, 8'hed, -1, 1'b0);
      drain();
`endif
      for (int i = 0; i < 8; i++) send(spot_a[i], spot_e[i], -1, 1'b0);
      drain();
      for (int i = 0; i < 256; i++) send(8'(i), fips[i], -1, 1'b1);
      drain();
      uniq = 0;
      for (int i = 0; i < 256; i++) uniq += int'(seen[i]);
      chk("unique_outputs", uniq, 256);
      for (int i = 0; i < 4; i++) send(kx_a[i], fips[kx_a[i]], i, 1'b0);
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
